// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS32 controller FSM with memory wait-state timeout and opcode trap
module multicycle_control_unit #(
    parameter int ALU_FUNC_W  = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter bit EXT_OPS     = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [5:0]            opc_i,
    input  logic [5:0]            func_i,
    input  logic                  aluZero_i,
    input  logic                  memReady_i,
    output logic                  memRead_o,
    output logic                  memWrite_o,
    output logic                  memIsInstr_o,
    output logic                  irWrite_o,
    output logic                  pcWrite_o,
    output logic [1:0]            pcSrc_o,
    output logic                  aluSrcA_o,
    output logic [1:0]            aluSrcB_o,
    output logic [ALU_FUNC_W-1:0] aluFunc_o,
    output logic                  bitXtend_o,
    output logic                  rfWriteEnable_o,
    output logic                  rfWriteAddrSel_o,
    output logic [1:0]            rfWriteDataSel_o,
    output logic                  instrDone_o,
    output logic                  invOpcode_o,
    output logic                  memTimeout_o,
    output logic                  halted_o,
    output logic [2:0]            state_o
);

    localparam logic [ALU_FUNC_W-1:0] ALU_ADD  = ALU_FUNC_W'(0);
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB  = ALU_FUNC_W'(1);
    localparam logic [ALU_FUNC_W-1:0] ALU_AND  = ALU_FUNC_W'(2);
    localparam logic [ALU_FUNC_W-1:0] ALU_OR   = ALU_FUNC_W'(3);
    localparam logic [ALU_FUNC_W-1:0] ALU_SLT  = ALU_FUNC_W'(4);
    localparam logic [ALU_FUNC_W-1:0] ALU_XOR  = ALU_FUNC_W'(5);
    localparam logic [ALU_FUNC_W-1:0] ALU_SLTU = ALU_FUNC_W'(6);

    // A zero timeout still needs a one-bit counter so the logic stays well formed.
    localparam int               CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_INV, C_R, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_LUI
    } cls_t;

    state_t                  state_q, state_d;
    cls_t                    cls_q, cls_d, dec_cls;
    logic [ALU_FUNC_W-1:0]   alu_q, alu_d, dec_alu;
    logic                    zext_q, zext_d, dec_zext;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    inv_q, inv_d, to_q, to_d;
    logic                    timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_MAX);

    // Instruction class, ALU op and extension mode from the raw IR fields.
    always_comb begin
        dec_cls  = C_INV;
        dec_alu  = ALU_ADD;
        dec_zext = 1'b0;
        unique case (opc_i)
            6'h00: begin
                dec_cls = C_R;
                unique case (func_i)
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h22, 6'h23: dec_alu = ALU_SUB;
                    6'h24:        dec_alu = ALU_AND;
                    6'h25:        dec_alu = ALU_OR;
                    6'h2A:        dec_alu = ALU_SLT;
                    6'h26: begin dec_alu = ALU_XOR;  dec_cls = EXT_OPS ? C_R : C_INV; end
                    6'h2B: begin dec_alu = ALU_SLTU; dec_cls = EXT_OPS ? C_R : C_INV; end
                    default:      dec_cls = C_INV;
                endcase
            end
            6'h02: dec_cls = C_J;
            6'h04: dec_cls = C_BEQ;
            6'h05: dec_cls = C_BNE;
            6'h08, 6'h09: dec_cls = C_IALU;
            6'h0C: begin dec_cls = C_IALU; dec_alu = ALU_AND; dec_zext = 1'b1; end
            6'h0D: begin dec_cls = C_IALU; dec_alu = ALU_OR;  dec_zext = 1'b1; end
            6'h0A: begin dec_cls = EXT_OPS ? C_IALU : C_INV; dec_alu = ALU_SLT;  end
            6'h0B: begin dec_cls = EXT_OPS ? C_IALU : C_INV; dec_alu = ALU_SLTU; end
            6'h0E: begin dec_cls = EXT_OPS ? C_IALU : C_INV; dec_alu = ALU_XOR;  end
            6'h0F: dec_cls = EXT_OPS ? C_LUI : C_INV;
            6'h23: dec_cls = C_LW;
            6'h2B: dec_cls = C_SW;
            default: dec_cls = C_INV;
        endcase
    end

    // State register, latched instruction class, wait counter and sticky trap flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cls_q   <= C_INV;
            alu_q   <= ALU_ADD;
            zext_q  <= 1'b0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
            zext_q  <= zext_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            to_q    <= to_d;
        end
    end

    // Next state and datapath control; every strobe defaults low.
    always_comb begin
        state_d          = state_q;
        cls_d            = cls_q;
        alu_d            = alu_q;
        zext_d           = zext_q;
        cnt_d            = cnt_q;
        inv_d            = inv_q;
        to_d             = to_q;
        memRead_o        = 1'b0;
        memWrite_o       = 1'b0;
        memIsInstr_o     = 1'b0;
        irWrite_o        = 1'b0;
        pcWrite_o        = 1'b0;
        pcSrc_o          = 2'd0;
        aluSrcA_o        = 1'b0;
        aluSrcB_o        = 2'd0;
        aluFunc_o        = ALU_ADD;
        bitXtend_o       = 1'b0;
        rfWriteEnable_o  = 1'b0;
        rfWriteAddrSel_o = 1'b0;
        rfWriteDataSel_o = 2'd0;
        instrDone_o      = 1'b0;
        halted_o         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_FETCH: begin
                memRead_o    = 1'b1;
                memIsInstr_o = 1'b1;
                aluSrcB_o    = 2'd1;
                if (memReady_i) begin
                    irWrite_o = 1'b1;
                    pcWrite_o = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_DECODE;
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                aluSrcB_o = 2'd3;
                cls_d     = dec_cls;
                alu_d     = dec_alu;
                zext_d    = dec_zext;
                unique case (dec_cls)
                    C_INV: begin
                        inv_d   = 1'b1;
                        state_d = S_TRAP;
                    end
                    C_J: begin
                        pcWrite_o   = 1'b1;
                        pcSrc_o     = 2'd2;
                        instrDone_o = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_FETCH;
                    end
                    C_LUI:   state_d = S_WB;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                aluSrcA_o = 1'b1;
                unique case (cls_q)
                    C_R: begin
                        aluFunc_o = alu_q;
                        state_d   = S_WB;
                    end
                    C_IALU: begin
                        aluSrcB_o  = 2'd2;
                        aluFunc_o  = alu_q;
                        bitXtend_o = zext_q;
                        state_d    = S_WB;
                    end
                    C_LW, C_SW: begin
                        aluSrcB_o = 2'd2;
                        cnt_d     = '0;
                        state_d   = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        aluFunc_o   = ALU_SUB;
                        pcWrite_o   = (cls_q == C_BEQ) ? aluZero_i : !aluZero_i;
                        pcSrc_o     = 2'd1;
                        instrDone_o = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                memRead_o  = (cls_q == C_LW);
                memWrite_o = (cls_q == C_SW);
                if (memReady_i) begin
                    cnt_d = '0;
                    if (cls_q == C_SW) begin
                        instrDone_o = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rfWriteEnable_o  = 1'b1;
                rfWriteAddrSel_o = (cls_q == C_R);
                rfWriteDataSel_o = (cls_q == C_LW) ? 2'd1 : ((cls_q == C_LUI) ? 2'd2 : 2'd0);
                instrDone_o      = 1'b1;
                cnt_d            = '0;
                state_d          = S_FETCH;
            end
            S_TRAP: halted_o = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    assign invOpcode_o  = inv_q;
    assign memTimeout_o = to_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3,
                           A_SLT = 3'd4, A_XOR = 3'd5, A_SLTU = 3'd6;
    localparam int K_INV = 0, K_R = 1, K_IALU = 2, K_LW = 3, K_SW = 4,
                   K_BEQ = 5, K_BNE = 6, K_J = 7, K_LUI = 8;
    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opc = 6'h00;
    logic [5:0] func = 6'h20;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       mem_read[2], mem_write[2], mem_is_instr[2], ir_write[2], pc_write[2];
    logic [1:0] pc_src[2], alu_src_b[2], rf_wds[2];
    logic       alu_src_a[2], bit_xtend[2], rf_we[2], rf_was[2], instr_done[2];
    logic [2:0] alu_func[2], st[2];
    logic       inv_opc[2], mem_to[2], halted[2];

    int errors = 0;
    int checks = 0;

    // Instance 0: full instruction set; instance 1: extended ops decode as invalid.
    multicycle_control_unit #(.ALU_FUNC_W(3), .MEM_TIMEOUT(TMO), .EXT_OPS(1'b1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .opc_i(opc), .func_i(func), .aluZero_i(alu_zero),
        .memReady_i(mem_ready), .memRead_o(mem_read[0]), .memWrite_o(mem_write[0]),
        .memIsInstr_o(mem_is_instr[0]), .irWrite_o(ir_write[0]), .pcWrite_o(pc_write[0]),
        .pcSrc_o(pc_src[0]), .aluSrcA_o(alu_src_a[0]), .aluSrcB_o(alu_src_b[0]),
        .aluFunc_o(alu_func[0]), .bitXtend_o(bit_xtend[0]), .rfWriteEnable_o(rf_we[0]),
        .rfWriteAddrSel_o(rf_was[0]), .rfWriteDataSel_o(rf_wds[0]), .instrDone_o(instr_done[0]),
        .invOpcode_o(inv_opc[0]), .memTimeout_o(mem_to[0]), .halted_o(halted[0]), .state_o(st[0]));

    multicycle_control_unit #(.ALU_FUNC_W(3), .MEM_TIMEOUT(TMO), .EXT_OPS(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .opc_i(opc), .func_i(func), .aluZero_i(alu_zero),
        .memReady_i(mem_ready), .memRead_o(mem_read[1]), .memWrite_o(mem_write[1]),
        .memIsInstr_o(mem_is_instr[1]), .irWrite_o(ir_write[1]), .pcWrite_o(pc_write[1]),
        .pcSrc_o(pc_src[1]), .aluSrcA_o(alu_src_a[1]), .aluSrcB_o(alu_src_b[1]),
        .aluFunc_o(alu_func[1]), .bitXtend_o(bit_xtend[1]), .rfWriteEnable_o(rf_we[1]),
        .rfWriteAddrSel_o(rf_was[1]), .rfWriteDataSel_o(rf_wds[1]), .instrDone_o(instr_done[1]),
        .invOpcode_o(inv_opc[1]), .memTimeout_o(mem_to[1]), .halted_o(halted[1]), .state_o(st[1]));

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (act=running req=finished)");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: sequencing position, wait counter and sticky flags per instance.
    int m_state[2] = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    bit m_inv[2]   = '{1'b0, 1'b0};
    bit m_to[2]    = '{1'b0, 1'b0};
    bit m_ext[2]   = '{1'b1, 1'b0};

    // Instruction set table; opc/func are stable for the whole instruction so the model classifies every cycle.
    function automatic void classify(input logic [5:0] o, input logic [5:0] f, input bit ext,
                                     output int c, output logic [2:0] af, output bit zx);
        c = K_INV; af = A_ADD; zx = 1'b0;
        case (o)
            6'h00: case (f)
                6'h20, 6'h21: begin c = K_R; af = A_ADD; end
                6'h22, 6'h23: begin c = K_R; af = A_SUB; end
                6'h24: begin c = K_R; af = A_AND; end
                6'h25: begin c = K_R; af = A_OR;  end
                6'h2A: begin c = K_R; af = A_SLT; end
                6'h26: if (ext) begin c = K_R; af = A_XOR;  end
                6'h2B: if (ext) begin c = K_R; af = A_SLTU; end
                default: c = K_INV;
            endcase
            6'h02: c = K_J;
            6'h04: c = K_BEQ;
            6'h05: c = K_BNE;
            6'h08, 6'h09: c = K_IALU;
            6'h0C: begin c = K_IALU; af = A_AND; zx = 1'b1; end
            6'h0D: begin c = K_IALU; af = A_OR;  zx = 1'b1; end
            6'h0A: if (ext) begin c = K_IALU; af = A_SLT;  end
            6'h0B: if (ext) begin c = K_IALU; af = A_SLTU; end
            6'h0E: if (ext) begin c = K_IALU; af = A_XOR;  end
            6'h0F: if (ext) c = K_LUI;
            6'h23: c = K_LW;
            6'h2B: c = K_SW;
            default: c = K_INV;
        endcase
    endfunction

    function automatic logic [24:0] dut_vec(input int k);
        return {mem_read[k], mem_write[k], mem_is_instr[k], ir_write[k], pc_write[k], pc_src[k],
                alu_src_a[k], alu_src_b[k], alu_func[k], bit_xtend[k], rf_we[k], rf_was[k],
                rf_wds[k], instr_done[k], inv_opc[k], mem_to[k], halted[k], st[k]};
    endfunction

    function automatic logic [24:0] exp_vec(input int k);
        int c; logic [2:0] af; bit zx;
        logic mr, mw, mii, irw, pcw, asa, bx, we, was, dn, hl;
        logic [1:0] pcs, asb, wds;
        logic [2:0] fo;
        mr = 0; mw = 0; mii = 0; irw = 0; pcw = 0; asa = 0; bx = 0; we = 0; was = 0; dn = 0; hl = 0;
        pcs = 2'd0; asb = 2'd0; wds = 2'd0; fo = A_ADD;
        if (!rst_n) return 25'd0;
        classify(opc, func, m_ext[k], c, af, zx);
        case (m_state[k])
            1: begin mr = 1; mii = 1; asb = 2'd1; irw = mem_ready; pcw = mem_ready; end
            2: begin asb = 2'd3; if (c == K_J) begin pcw = 1; pcs = 2'd2; dn = 1; end end
            3: begin
                asa = 1;
                if (c == K_R) fo = af;
                if (c == K_IALU) begin asb = 2'd2; fo = af; bx = zx; end
                if (c == K_LW || c == K_SW) asb = 2'd2;
                if (c == K_BEQ || c == K_BNE) begin
                    fo = A_SUB; pcs = 2'd1; dn = 1;
                    pcw = (c == K_BEQ) ? alu_zero : ~alu_zero;
                end
            end
            4: begin mr = (c == K_LW); mw = (c == K_SW); dn = (c == K_SW) && mem_ready; end
            5: begin we = 1; was = (c == K_R); wds = (c == K_LW) ? 2'd1 : (c == K_LUI) ? 2'd2 : 2'd0; dn = 1; end
            7: hl = 1;
            default: ;
        endcase
        return {mr, mw, mii, irw, pcw, pcs, asa, asb, fo, bx, we, was, wds, dn,
                m_inv[k], m_to[k], hl, 3'(m_state[k])};
    endfunction

    function automatic void advance(input int k);
        int c; logic [2:0] af; bit zx; int prev;
        if (!rst_n) begin
            m_state[k] = 0; m_cnt[k] = 0; m_inv[k] = 0; m_to[k] = 0;
            return;
        end
        classify(opc, func, m_ext[k], c, af, zx);
        prev = m_state[k];
        case (prev)
            0: m_state[k] = 1;
            1, 4: begin
                if (mem_ready) begin
                    m_cnt[k] = 0;
                    if (prev == 1) m_state[k] = 2;
                    else m_state[k] = (c == K_SW) ? 1 : 5;
                end else if (m_cnt[k] == TMO) begin
                    m_state[k] = 7; m_to[k] = 1;
                end else m_cnt[k]++;
            end
            2: begin
                if (c == K_INV) begin m_state[k] = 7; m_inv[k] = 1; end
                else if (c == K_J) m_state[k] = 1;
                else if (c == K_LUI) m_state[k] = 5;
                else m_state[k] = 3;
            end
            3: m_state[k] = (c == K_LW || c == K_SW) ? 4 : (c == K_BEQ || c == K_BNE) ? 1 : 5;
            5: m_state[k] = 1;
            default: ;
        endcase
        if (m_state[k] != prev && (m_state[k] == 1 || m_state[k] == 4)) m_cnt[k] = 0;
    endfunction

    always @(posedge clk) begin
        advance(0);
        advance(1);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [24:0] a, e;
            a = dut_vec(k);
            e = exp_vec(k);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model_dut%0d: got %h expected %h at t=%0t", k, a, e, $time);
            end
        end
    end

    task automatic cyc(input int es);
        @(negedge clk);
        chk("state_seq", int'(st[0]), es);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = instr_done[0];
            @(posedge clk); #1;
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL instr_timeout: got no instrDone expected instrDone within 40 cycles (opc=%h)", opc);
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        opc = o; func = f; alu_zero = z;
        wait_done();
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    logic [5:0] base_ops[12][2] = '{'{6'h00, 6'h21}, '{6'h00, 6'h22}, '{6'h00, 6'h23}, '{6'h00, 6'h24},
                                    '{6'h00, 6'h25}, '{6'h00, 6'h2A}, '{6'h08, 6'h00}, '{6'h09, 6'h00},
                                    '{6'h0C, 6'h00}, '{6'h0D, 6'h00}, '{6'h02, 6'h00}, '{6'h23, 6'h00}};
    logic [5:0] ext_ops[5][2]  = '{'{6'h00, 6'h26}, '{6'h00, 6'h2B}, '{6'h0A, 6'h00}, '{6'h0B, 6'h00},
                                   '{6'h0F, 6'h00}};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_state", int'(st[0]), 0);
        chk("rst_memread", int'(mem_read[0]), 0);
        chk("rst_halted", int'(halted[0]), 0);
        @(posedge clk); #1;
        rst_n = 1;

        // ADD: IDLE, FETCH, DECODE, EXEC, WB
        opc = 6'h00; func = 6'h20;
        cyc(0); cyc(1); cyc(2); cyc(3);
        @(negedge clk);
        chk("add_wb_state", int'(st[0]), 5);
        chk("add_wb_rfwe", int'(rf_we[0]), 1);
        chk("add_wb_addrsel", int'(rf_was[0]), 1);
        chk("add_wb_done", int'(instr_done[0]), 1);
        @(posedge clk); #1;

        // LW with three wait states in MEM
        opc = 6'h23;
        cyc(1); cyc(2); cyc(3);
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1;
            @(negedge clk);
            chk("lw_mem_state", int'(st[0]), 4);
            chk("lw_mem_read", int'(mem_read[0]), 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("lw_wb_state", int'(st[0]), 5);
        chk("lw_wb_datasel", int'(rf_wds[0]), 1);
        @(posedge clk); #1;

        // SW zero wait
        opc = 6'h2B;
        cyc(1); cyc(2); cyc(3);
        @(negedge clk);
        chk("sw_mem_write", int'(mem_write[0]), 1);
        chk("sw_mem_done", int'(instr_done[0]), 1);
        @(posedge clk); #1;

        // Branches: {opc, aluZero, expected pcWrite}
        for (int b = 0; b < 4; b++) begin
            opc = (b < 2) ? 6'h04 : 6'h05;
            alu_zero = (b == 0 || b == 3);
            cyc(1); cyc(2);
            @(negedge clk);
            chk("br_state", int'(st[0]), 3);
            chk("br_pcwrite", int'(pc_write[0]), (b == 0 || b == 2) ? 1 : 0);
            chk("br_pcsrc", int'(pc_src[0]), 1);
            @(posedge clk); #1;
        end

        foreach (base_ops[i]) run_instr(base_ops[i][0], base_ops[i][1], 1'b0);

        // XORI: normal on instance 0, trap on instance 1
        opc = 6'h0E; func = 6'h00;
        cyc(1);
        @(negedge clk);
        chk("xori1_decode", int'(st[1]), 2);
        chk("xori1_pcwrite", int'(pc_write[1]), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("xori1_trap", int'(st[1]), 7);
        chk("xori1_inv", int'(inv_opc[1]), 1);
        chk("xori1_rfwe", int'(rf_we[1]), 0);
        chk("xori0_exec", int'(st[0]), 3);
        wait_done();

        foreach (ext_ops[i]) run_instr(ext_ops[i][0], ext_ops[i][1], 1'b0);

        // FETCH timeout: 16 FETCH cycles (counter 0..15), then TRAP
        mem_ready = 0;
        for (int i = 0; i < 16; i++) cyc(1);
        @(negedge clk);
        chk("tmo_state", int'(st[0]), 7);
        chk("tmo_flag", int'(mem_to[0]), 1);
        chk("tmo_halted", int'(halted[0]), 1);
        chk("tmo_memread", int'(mem_read[0]), 0);
        @(posedge clk); #1;

        // Unknown opcode 0x3F
        mem_ready = 1;
        opc = 6'h3F;
        pulse_reset();
        cyc(0); cyc(1);
        @(negedge clk);
        chk("inv_decode_pcw", int'(pc_write[0]), 0);
        chk("inv_decode_rfwe", int'(rf_we[0]), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("inv_trap", int'(st[0]), 7);
        chk("inv_flag", int'(inv_opc[0]), 1);
        chk("inv_tmo_clear", int'(mem_to[0]), 0);
        @(posedge clk); #1;

        // Reset asserted mid-MEM of SW
        opc = 6'h2B;
        pulse_reset();
        cyc(0); cyc(1); cyc(2); cyc(3);
        mem_ready = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_state", int'(st[0]), 0);
        chk("midrst_memwrite", int'(mem_write[0]), 0);
        chk("midrst_zero", (dut_vec(0) == 25'd0) ? 1 : 0, 1);
        mem_ready = 1;
        @(posedge clk); #1;
        rst_n = 1;
        cyc(0); cyc(1);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
